foc_dq_seq: RTL

Sequencer for the current-feedback front end of the FOC loop. On each ADC sample it launches the Clarke stage and the CORDIC sin/cos stage in parallel and waits for both to finish. It then feeds their results to the Park stage and returns the D/Q currents with a single valid pulse. It also detects stage timeouts and sample overruns.

---
 rtl/foc_dq_seq.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/foc_dq_seq.sv
// -----------------------------------------------------------------------------
// foc_dq_seq
//
// Sequencer for the current-feedback front end of the FOC loop. Each accepted
// ADC sample launches the Clarke and CORDIC sin/cos stages in parallel. Once
// both have reported, their results are registered as Park operands and Park
// is started. The Park D/Q results are registered and announced with a single
// dq_valid pulse. Stage timeouts raise a sticky fault. Samples that arrive
// while busy or faulted are dropped and counted.
//
// No arithmetic is done here. Data words pass through unchanged at D_WIDTH.
//
// Ports
//   clk, rstb                     clock, asynchronous active-low reset
//   sample_valid                  new phase currents available (pulse)
//   clarke_start, cordic_start    front-end start pulses
//   clarke_done, cordic_done      front-end completion pulses
//   clarke_alpha/beta             Clarke results, valid with clarke_done
//   cordic_sin/cos                CORDIC results, valid with cordic_done
//   park_start                    Park start pulse
//   park_alpha/beta/sin/cos       registered Park operands
//   park_done                     Park completion (pulse or level)
//   park_d, park_q                Park results
//   d_out, q_out                  registered D/Q results
//   dq_valid                      pulse when d_out/q_out update
//   busy                          high in every state except IDLE
//   fault, fault_clr              sticky timeout flag and its clear
//   overrun_cnt                   saturating dropped-sample count
// -----------------------------------------------------------------------------
module foc_dq_seq #(
    parameter int D_WIDTH  = 18,
    parameter int PARK_LAT = 2,
    parameter int TIMEOUT  = 64,
    parameter int OVR_W    = 8
) (
    input  logic                      clk,
    input  logic                      rstb,
    input  logic                      sample_valid,
    output logic                      clarke_start,
    output logic                      cordic_start,
    input  logic                      clarke_done,
    input  logic                      cordic_done,
    input  logic signed [D_WIDTH-1:0] clarke_alpha,
    input  logic signed [D_WIDTH-1:0] clarke_beta,
    input  logic signed [D_WIDTH-1:0] cordic_sin,
    input  logic signed [D_WIDTH-1:0] cordic_cos,
    output logic                      park_start,
    output logic signed [D_WIDTH-1:0] park_alpha,
    output logic signed [D_WIDTH-1:0] park_beta,
    output logic signed [D_WIDTH-1:0] park_sin,
    output logic signed [D_WIDTH-1:0] park_cos,
    input  logic                      park_done,
    input  logic signed [D_WIDTH-1:0] park_d,
    input  logic signed [D_WIDTH-1:0] park_q,
    output logic signed [D_WIDTH-1:0] d_out,
    output logic signed [D_WIDTH-1:0] q_out,
    output logic                      dq_valid,
    output logic                      busy,
    output logic                      fault,
    input  logic                      fault_clr,
    output logic [OVR_W-1:0]          overrun_cnt
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FRONT = 2'd1;
    localparam logic [1:0] S_PARK  = 2'd2;
    localparam logic [1:0] S_OUT   = 2'd3;

    localparam logic [CNT_W-1:0] PARK_LAT_C = CNT_W'(PARK_LAT);
    // The counter starts at 0 on state entry, so the last permitted wait
    // cycle is the one where it reads TIMEOUT-1.
    localparam logic [CNT_W-1:0] TO_LAST_C  = CNT_W'(TIMEOUT - 1);

    // Saturating increment for the overrun counter.
    function automatic logic [OVR_W-1:0] sat_inc(input logic [OVR_W-1:0] v);
        sat_inc = (&v) ? v : v + OVR_W'(1);
    endfunction

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [CNT_W-1:0] wait_cnt;
    logic             clarke_got;
    logic             cordic_got;

    logic enter_front;
    logic front_done;
    logic park_acc;
    logic timeout_hit;
    logic drop_sample;

    // -------------------------------------------------------------------------
    // Control decode
    // -------------------------------------------------------------------------
    assign enter_front = (state == S_IDLE) && sample_valid && !fault;

    // Both front-end results present, including any that arrive this cycle.
    assign front_done  = (state == S_FRONT)
                         && (clarke_got || clarke_done)
                         && (cordic_got || cordic_done);

    // park_done may be a level, so only trust it once Park has had its latency.
    assign park_acc    = (state == S_PARK) && park_done && (wait_cnt >= PARK_LAT_C);

    // Completion in the last allowed cycle wins over the timeout.
    assign timeout_hit = (wait_cnt == TO_LAST_C)
                         && (((state == S_FRONT) && !front_done)
                          || ((state == S_PARK)  && !park_acc));

    assign drop_sample = sample_valid && ((state != S_IDLE) || fault);

    assign busy        = (state != S_IDLE);

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (enter_front) state_nxt = S_FRONT;
            end
            S_FRONT: begin
                if (front_done)       state_nxt = S_PARK;
                else if (timeout_hit) state_nxt = S_IDLE;
            end
            S_PARK: begin
                if (park_acc)         state_nxt = S_OUT;
                else if (timeout_hit) state_nxt = S_IDLE;
            end
            S_OUT: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Control registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state        <= S_IDLE;
            wait_cnt     <= '0;
            clarke_got   <= 1'b0;
            cordic_got   <= 1'b0;
            clarke_start <= 1'b0;
            cordic_start <= 1'b0;
            park_start   <= 1'b0;
            dq_valid     <= 1'b0;
            fault        <= 1'b0;
            overrun_cnt  <= '0;
        end else begin
            state        <= state_nxt;
            clarke_start <= enter_front;
            cordic_start <= enter_front;
            park_start   <= front_done;
            dq_valid     <= park_acc;

            // Wait counter: zero in the first cycle of FRONT and of PARK.
            if (enter_front || front_done) begin
                wait_cnt <= '0;
            end else if ((state == S_FRONT) || (state == S_PARK)) begin
                wait_cnt <= wait_cnt + CNT_W'(1);
            end else begin
                wait_cnt <= '0;
            end

            if (enter_front) begin
                clarke_got <= 1'b0;
                cordic_got <= 1'b0;
            end else if (state == S_FRONT) begin
                if (clarke_done) clarke_got <= 1'b1;
                if (cordic_done) cordic_got <= 1'b1;
            end

            // A timeout in the same cycle as fault_clr keeps the fault set.
            if (timeout_hit) begin
                fault <= 1'b1;
            end else if (fault_clr) begin
                fault <= 1'b0;
            end

            if (drop_sample) begin
                overrun_cnt <= sat_inc(overrun_cnt);
            end
        end
    end

    // -------------------------------------------------------------------------
    // Operand capture (FRONT) and result capture (PARK acceptance)
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            park_alpha <= '0;
            park_beta  <= '0;
            park_sin   <= '0;
            park_cos   <= '0;
            d_out      <= '0;
            q_out      <= '0;
        end else begin
            // A repeated done simply overwrites that stage's operands.
            if ((state == S_FRONT) && clarke_done) begin
                park_alpha <= clarke_alpha;
                park_beta  <= clarke_beta;
            end
            if ((state == S_FRONT) && cordic_done) begin
                park_sin <= cordic_sin;
                park_cos <= cordic_cos;
            end
            if (park_acc) begin
                d_out <= park_d;
                q_out <= park_q;
            end
        end
    end

endmodule
